// File: rtl/spi_controller.sv
// SPI initiator: single-word full-duplex transfers, all four CPOL/CPHA modes, programmable sclk divider.
// Define SPI_CTRL_LSB_FIRST_EN to shift LSB-first; the default build is MSB-first.
module spi_controller #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);
`ifdef SPI_CTRL_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif
    localparam int HP_N = 2 * DATA_W;
    localparam int HP_W = $clog2(HP_N + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic [HP_W-1:0]   hp_q, hp_d, k;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_q, rx_d;
    logic              sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d, done_q, done_d;
    logic              tick, edge_ev, leading, do_sample, do_shift;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        hp_d      = hp_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_d      = rx_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        edge_ev   = 1'b0;
        leading   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        tick      = (cnt_q == div_q);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        k         = hp_q + 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = LEAD;
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    cs_n_d  = 1'b0;
                    sclk_d  = cpol;
                    hp_d    = '0;
                    tx_sr_d = tx_data;
                    // CPHA=0 needs the first bit valid before the first (sampling) edge
                    if (!cpha) begin
                        mosi_d  = LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
                        tx_sr_d = LSB_FIRST ? (tx_data >> 1) : (tx_data << 1);
                    end
                end
            end
            LEAD: if (tick) begin
                state_d = XFER;
                edge_ev = 1'b1;
            end
            XFER: if (tick) begin
                if (hp_q == HP_W'(HP_N)) state_d = TRAIL;
                else                     edge_ev = 1'b1;
            end
            TRAIL: if (tick) begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
                rx_d    = rx_sr_q;
            end
            default: state_d = IDLE;
        endcase

        // Each edge opens half-period k; odd k is a leading edge.
        if (edge_ev) begin
            hp_d      = k;
            sclk_d    = ~sclk_q;
            leading   = k[0];
            do_sample = leading ^ cpha_q;
            do_shift  = !do_sample && (k != HP_W'(HP_N));
            if (do_sample)
                rx_sr_d = LSB_FIRST ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
            if (do_shift) begin
                mosi_d  = LSB_FIRST ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
                tx_sr_d = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            hp_q    <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            hp_q    <= hp_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: pattern slave / loopback slave, timing, mode and reset checks.
module tb_spi_controller;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic       miso, busy, done, sclk, cs_n, mosi;
    logic [7:0] tx_data = 8'h00, clk_div = 8'h00, rx_data;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    spi_controller #(.DATA_W(8), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .clk_div(clk_div),
        .cpol(cpol), .cpha(cpha), .busy(busy), .done(done), .rx_data(rx_data),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    // Mode-0 pattern slave: MSB of pat first, next bit after each falling sclk.
    logic       use_pat = 1'b0;
    logic [7:0] pat = 8'h00;
    int         tcnt = 0, tbase = 0, sidx;
    always @(negedge sclk) tcnt <= tcnt + 1;
    always @(negedge cs_n) tbase <= tcnt;
    assign sidx = tcnt - tbase;
    assign miso = use_pat ? ((sidx >= 0 && sidx < 8) ? pat[3'(7 - sidx)] : 1'b0) : mosi;

    logic [7:0] rec = 8'h00;
    always @(posedge sclk) rec <= {rec[6:0], mosi};

    // sclk run lengths while cs_n is low; every run ended by a toggle must equal exp_hp
    int   run = 0, runs = 0, badrun = 0, exp_hp = 1;
    logic psclk = 1'b0;
    always @(negedge clk) begin
        if (cs_n) run <= 0;
        else if (run == 0) run <= 1;
        else if (sclk != psclk) begin
            runs <= runs + 1;
            if (run != exp_hp) badrun <= badrun + 1;
            run <= 1;
        end else run <= run + 1;
        psclk <= sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] div, input logic pol,
                           input logic pha, output int low_cnt, output int done_at,
                           output logic cs_d, output logic busy_d, output logic sclk_d);
        @(negedge clk);
        tx_data = tx; clk_div = div; cpol = pol; cpha = pha; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        low_cnt = 0; done_at = 0; cs_d = 1'b0; busy_d = 1'b1; sclk_d = 1'bx;
        for (int k = 1; k <= 3000; k++) begin
            if (k > 1) @(negedge clk);
            if (!cs_n) low_cnt++;
            if (done) begin
                done_at = k; cs_d = cs_n; busy_d = busy; sclk_d = sclk;
                break;
            end
        end
    endtask

    int   low, dat, ndone, gap, r0, b0, d1, d2;
    logic cs_d, busy_d, sclk_d;
    logic [1:0] m;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        rst_n = 1'b1;

        // mode 0, fastest clock, pattern slave returns 0x3C
        use_pat = 1'b1; pat = 8'h3C;
        do_xfer(8'hA5, 8'd0, 1'b0, 1'b0, low, dat, cs_d, busy_d, sclk_d);
        check("m0_low", low, 18);
        check("m0_done_at", dat, 19);
        check("m0_cs_at_done", cs_d, 1);
        check("m0_busy_at_done", busy_d, 0);
        check("m0_rx", rx_data, 8'h3C);
        check("m0_mosi_bits", rec, 8'hA5);
        use_pat = 1'b0;

        // all four modes, clk_div=3, loopback
        exp_hp = 4;
        for (int i = 0; i < 4; i++) begin
            m = 2'(i);
            r0 = runs; b0 = badrun;
            do_xfer(8'h5A, 8'd3, m[1], m[0], low, dat, cs_d, busy_d, sclk_d);
            @(negedge clk);
            check($sformatf("mode%0d_rx", i), rx_data, 8'h5A);
            check($sformatf("mode%0d_done_at", i), dat, 73);
            check($sformatf("mode%0d_sclk_done", i), sclk_d, m[1]);
            check($sformatf("mode%0d_sclk_idle", i), sclk, m[1]);
            check($sformatf("mode%0d_edges", i), runs - r0, 16);
            check($sformatf("mode%0d_badhp", i), badrun - b0, 0);
        end

        // start mid-transfer with new inputs is ignored
        @(negedge clk);
        tx_data = 8'h5A; clk_div = 8'd1; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ndone = 0; dat = 0;
        for (int k = 1; k <= 120; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 10) begin tx_data = 8'hFF; clk_div = 8'd0; cpol = 1'b1; start = 1'b1; end
            if (k == 11) start = 1'b0;
            if (done) begin ndone++; if (dat == 0) dat = k; end
        end
        check("ign_ndone", ndone, 1);
        check("ign_done_at", dat, 37);
        check("ign_rx", rx_data, 8'h5A);
        check("ign_sclk_idle", sclk, 0);
        cpol = 1'b0;

        // start held through done: back-to-back frames
        @(negedge clk);
        tx_data = 8'h3C; clk_div = 8'd0; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        ndone = 0; gap = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = k; check("b2b_rx1", rx_data, 8'h3C); tx_data = 8'hC3; end
                else begin d2 = k; check("b2b_rx2", rx_data, 8'hC3); break; end
            end
            if (ndone == 1 && cs_n) gap++;
            if (ndone == 1 && !cs_n) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_ndone", ndone, 2);
        check("b2b_gap", gap, 1);
        check("b2b_done1", d1, 19);
        check("b2b_done2", d2, 38);

        // asynchronous reset mid-transfer
        @(negedge clk);
        tx_data = 8'h81; clk_div = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_sclk", sclk, 0);
        check("ar_cs_n", cs_n, 1);
        check("ar_mosi", mosi, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_rx", rx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || !cs_n) ndone++;
        end
        check("ar_quiet", ndone, 0);
        do_xfer(8'h81, 8'd0, 1'b0, 1'b0, low, dat, cs_d, busy_d, sclk_d);
        check("ar_next_rx", rx_data, 8'h81);
        check("ar_next_done", dat, 19);
        check("ar_next_low", low, 18);

        // bit order
        do_xfer(8'h01, 8'd0, 1'b0, 1'b0, low, dat, cs_d, busy_d, sclk_d);
        check("ord_rx", rx_data, 8'h01);
`ifdef SPI_CTRL_LSB_FIRST_EN
        check("ord_first_bit", rec[7], 1);
`else
        check("ord_first_bit", rec[7], 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
